// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: occupancy states and default widths shared by the pipeline stage register
package pipe_stage_pkg;
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one payload register (data + PC) with load and clear
module pipe_stage_slot #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o
);
    logic [DATA_W-1:0] data_q;
    logic [PC_W-1:0]   pc_q;
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            data_q <= '0;
            pc_q   <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end
    assign data_o = data_q;
    assign pc_o   = pc_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with stall counter
// PIPE_STAGE_REG_SKID_EN adds a skid slot so in_ready is registered (2-entry storage)
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_xfer, out_xfer, head_ld, head_clr;
    logic [DATA_W-1:0] head_data_d;
    logic [PC_W-1:0]   head_pc_d;

    assign out_valid = state_q != EMPTY;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign stall_cnt = stall_q;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_ld, skid_clr;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;
    assign in_ready    = state_q != SKID;
    // head refills from the skid slot on drain, otherwise from upstream
    assign head_ld     = (in_xfer && (state_q == EMPTY || out_xfer)) || (state_q == SKID && out_xfer);
    assign head_data_d = state_q == SKID ? skid_data : in_data;
    assign head_pc_d   = state_q == SKID ? skid_pc : in_pc;
    assign skid_ld     = in_xfer && state_q == FULL && !out_xfer;
    assign skid_clr    = flush || (state_q == SKID && out_xfer);
    pipe_stage_slot #(.DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
        .clk(clk), .reset(reset), .load_i(skid_ld), .clear_i(skid_clr),
        .data_i(in_data), .pc_i(in_pc), .data_o(skid_data), .pc_o(skid_pc)
    );
`else
    assign in_ready    = !out_valid || out_ready;
    assign head_ld     = in_xfer;
    assign head_data_d = in_data;
    assign head_pc_d   = in_pc;
`endif

    // clearing on drain keeps out_data/out_pc at zero whenever the stage is empty
    assign head_clr = flush || (out_xfer && !head_ld);

    pipe_stage_slot #(.DATA_W(DATA_W), .PC_W(PC_W)) u_head (
        .clk(clk), .reset(reset), .load_i(head_ld), .clear_i(head_clr),
        .data_i(head_data_d), .pc_i(head_pc_d), .data_o(out_data), .pc_o(out_pc)
    );

    assign state_d = flush ? EMPTY
                   : state_q == EMPTY ? (in_xfer ? FULL : EMPTY)
                   : state_q == FULL  ? (in_xfer && !out_xfer ? SKID : out_xfer && !in_xfer ? EMPTY : FULL)
                   : (out_xfer ? FULL : SKID);
    assign stall_d = (out_valid && !out_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus against a queue reference model
module tb_pipe_stage_reg;
    logic        clk, reset, in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_data, in_pc, out_data, out_pc;
    logic [3:0]  stall_cnt;
    int          compared = 0, mismatched = 0;
    logic [31:0] md[$], mp[$];
    int          mcnt = 0;

    pipe_stage_reg #(.DATA_W(32), .PC_W(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pc(out_pc), .flush(flush), .stall_cnt(stall_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ir();
`ifdef PIPE_STAGE_REG_SKID_EN
        return md.size() < 2;
`else
        return md.size() == 0 || out_ready;
`endif
    endfunction

    task automatic model_edge();
        bit it, ot;
        it = in_valid && exp_ir();
        ot = md.size() > 0 && out_ready;
        if (md.size() > 0 && !out_ready && mcnt < 15) mcnt++;
        if (reset) begin
            md.delete(); mp.delete(); mcnt = 0;
        end else if (flush) begin
            md.delete(); mp.delete();
        end else begin
            if (ot) begin void'(md.pop_front()); void'(mp.pop_front()); end
            if (it) begin md.push_back(in_data); mp.push_back(in_pc); end
        end
    endtask

    task automatic cycle();
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_ir()));
        chk("out_valid", 32'(out_valid), 32'(md.size() > 0));
        chk("out_data", out_data, md.size() > 0 ? md[0] : 32'h0);
        chk("out_pc", out_pc, md.size() > 0 ? mp[0] : 32'h0);
        chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(bit v, bit r, logic [31:0] d, bit f = 0, bit rs = 0);
        in_valid = v; out_ready = r; in_data = d; in_pc = d + 32'h100; flush = f; reset = rs;
    endtask

    initial begin
        drive(1, 0, 32'h55, 0, 1);
        @(posedge clk);
        model_edge();
        #1;
        drive(0, 0, 32'h0);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_stall", 32'(stall_cnt), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 32'(k));
            cycle();
            chk("stream", out_data, 32'(k));
        end
        drive(0, 1, 32'h0);
        cycle();
        drive(1, 0, 32'hA);
        cycle();
        drive(0, 0, 32'h0);
        cycle();
        chk("full_in_ready", 32'(in_ready), 32'(exp_ir()));
        drive(1, 0, 32'hC, 1);
        cycle();
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_out_data", out_data, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h0);
            cycle();
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        drive(1, 0, 32'hA);
        cycle();
        drive(1, 0, 32'hB);
        cycle();
        drive(1, 0, 32'hD);
        cycle();
        chk("skid_in_ready", 32'(in_ready), 32'h0);
        drive(0, 1, 32'h0);
        #1;
        chk("skid_first", out_data, 32'hA);
        cycle();
        chk("skid_second", out_data, 32'hB);
        cycle();
`else
        drive(1, 1, 32'h77);
        cycle();
        drive(0, 0, 32'h0);
        #1;
        chk("nomacro_block", 32'(in_ready), 32'h0);
        out_ready = 1;
        #1;
        chk("nomacro_release", 32'(in_ready), 32'h1);
        cycle();
`endif
        drive(0, 0, 32'h0, 0, 1);
        cycle();
        drive(1, 0, 32'h99);
        cycle();
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 32'h0);
            cycle();
        end
        chk("saturate", 32'(stall_cnt), 32'd15);
        chk("sat_hold_data", out_data, 32'h99);
        for (int k = 0; k < 400; k++) begin
            drive($urandom % 4 != 0, $urandom % 3 != 0, $urandom, $urandom % 16 == 0, $urandom % 60 == 0);
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of instruction/data payload.
REQ-002 SHALL have parameter PC_W, default 32: width of PC payload.
REQ-003 SHALL have parameter CNT_W, default 16: width of stall-cycle counter.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: upstream holds a valid entry.
REQ-007 SHALL have port in_ready  output  1: stage accepts an entry this cycle.
REQ-008 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-009 SHALL have port in_pc  input  PC_W: upstream PC.
REQ-010 SHALL have port out_valid  output  1: stage presents a valid entry.
REQ-011 SHALL have port out_ready  input  1: downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  DATA_W: head payload.
REQ-013 SHALL have port out_pc  output  PC_W: head PC.
REQ-014 SHALL have port flush  input  1: synchronous clear of all content.
REQ-015 SHALL have port stall_cnt  output  CNT_W: cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 SHALL hold states EMPTY (0 entries), FULL (1 entry), SKID (2 entries; SKID only with macro).
REQ-018 SHALL transition EMPTY->FULL on in-transfer; FULL->EMPTY on out-transfer without in-transfer; FULL->FULL on both; FULL->SKID on in-transfer without out-transfer; SKID->FULL on out-transfer.
REQ-019 SHALL have latency one cycle: entry accepted at edge N is on out_* from edge N, order preserved.
REQ-020 SHALL hold out_data/out_pc stable while out_valid && !out_ready.
REQ-021 SHALL, on flush=1, at that edge set state EMPTY and zero all data, PC, and skid contents; the same-cycle in-transfer is discarded; flush does not affect stall_cnt.
REQ-022 SHALL increment stall_cnt each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1, with no wrap.
REQ-023 SHALL drive out_data=0 and out_pc=0 whenever out_valid=0.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, set state EMPTY, out_valid=0, out_data=0, out_pc=0, skid contents=0, stall_cnt=0.
REQ-025 SHALL give reset priority over flush and over all transfers; an entry mid-transfer when reset asserts is lost.

Configuration
REQ-026 SHALL use macro PIPE_STAGE_REG_SKID_EN.
REQ-027 SHALL, with PIPE_STAGE_REG_SKID_EN defined, register in_ready as (state != SKID), so in_ready has no combinational path from out_ready; 2-entry storage.
REQ-028 SHALL, without PIPE_STAGE_REG_SKID_EN, have in_ready = !out_valid || out_ready (combinational) and 1-entry storage; SKID unreachable.

Structure
REQ-029 SHALL place state enum (EMPTY/FULL/SKID) and default widths in shared package pipe_stage_pkg.
REQ-030 SHALL implement each storage entry as sub-module pipe_stage_slot (data+PC register with load and clear inputs), instantiated once or twice per macro.

Verification
REQ-031 SHALL test reset: reset=1 one cycle with in_valid=1 -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 next cycle.
REQ-032 SHALL test streaming: out_ready=1, in_data=0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on consecutive cycles, one-cycle latency.
REQ-033 SHALL test backpressure (SKID_EN): out_ready=0, push 0xA,0xB -> state SKID, in_ready=0, stall_cnt increments; release -> 0xA then 0xB, no loss.
REQ-034 SHALL test flush: FULL with 0xA, flush=1 with in_valid=1/in_data=0xC -> next cycle out_valid=0, out_data=0, 0xC never appears.
REQ-035 SHALL test saturation: CNT_W=4, out_ready=0 for 20 cycles with valid entry -> stall_cnt holds 15.
REQ-036 SHALL test no-macro build: out_ready=0 while FULL -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
